// File: rtl/uart_rx_if.sv
// Serial receive bundle for uart_rx: line/enable in, received byte and status pulses out.
// parity_err exists only when RX_PARITY_EN is defined.
interface uart_rx_if;
  logic       rx_en;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef RX_PARITY_EN
  logic       parity_err;

  modport master (output rx_en, rx, input data_out, rx_valid, frame_err, busy, parity_err);
  modport slave  (input rx_en, rx, output data_out, rx_valid, frame_err, busy, parity_err);
`else
  modport master (output rx_en, rx, input data_out, rx_valid, frame_err, busy);
  modport slave  (input rx_en, rx, output data_out, rx_valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling with BAUD_DIV clocks per bit.
// Define RX_PARITY_EN to add an even-parity bit between bit 7 and the stop bit.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((BAUD_DIV / 2) - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_out_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             busy_q;
  logic             armed_q;
  logic             par_ok_q;
  logic             parity_err_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             rx_s;
  logic             half_hit;
  logic             bit_hit;

  // Two-flop synchronizer; idles high out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s     = sync2_q;
  assign half_hit = (cnt_q == HALF_LAST);
  assign bit_hit  = (cnt_q == BIT_LAST);

  // armed_q blocks a new start after a framing error until the line is seen high (break)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      data_out_q   <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
      armed_q      <= 1'b0;
      par_ok_q     <= 1'b0;
    end else begin
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      if (!bus.rx_en) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
        idx_q   <= 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_s) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= S_START;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_START: begin
            if (half_hit) begin
              cnt_q <= '0;
              idx_q <= 3'd0;
              if (rx_s) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (bit_hit) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[7:1]};
              idx_q   <= idx_q + 3'd1;
              if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_PARITY: begin
            if (bit_hit) begin
              cnt_q    <= '0;
              par_ok_q <= ~(^{rx_s, shift_q});
              state_q  <= S_STOP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_STOP: begin
            if (bit_hit) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (!rx_s) begin
                frame_err_q <= 1'b1;
                armed_q     <= 1'b0;
              end
`ifdef RX_PARITY_EN
              else if (!par_ok_q) begin
                parity_err_q <= 1'b1;
              end
`endif
              else begin
                data_out_q <= shift_q;
                rx_valid_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
`ifdef RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, a frame-timing model checked every cycle,
// plus literal expectations for latency and received values.
module tb_uart_rx;

  localparam int unsigned B    = 24;
  localparam int unsigned HALF = B / 2;
`ifdef RX_PARITY_EN
  localparam int unsigned NSTOP = 10;
  localparam int          LAT   = 255;
`else
  localparam int unsigned NSTOP = 9;
  localparam int          LAT   = 231;
`endif
  // drive cycle -> pulse cycle: 2 sync flops, IDLE decision, half bit, NSTOP bits, output register
  localparam int PULSE_OFS = 3 + int'(HALF) + int'(NSTOP * B);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if bus ();
  uart_rx #(.BAUD_DIV(B)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int         n;
    int         busy_end;
    int         pulse;
    int         kind;  // 0 none, 1 valid, 2 frame error, 3 parity error
    logic [7:0] data;
  } rec_t;

  rec_t       recs[$];
  int         cyc = 0;
  int         reset_cyc = 0;
  int         n_checks = 0;
  int         n_errs = 0;
  logic       chk_on = 1'b0;
  int         nvalid = 0;
  int         nferr = 0;
  int         nperr = 0;
  int         last_valid_cyc = 0;
  int         last_busy_cyc = 0;
  logic [7:0] vhist[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Expected outputs at cycle c from the list of frames put on the line
  function automatic void model(input int c, output logic eb, output logic ev, output logic ef,
                                output logic ep, output logic [7:0] ed);
    int best;
    best = -1;
    eb = 1'b0; ev = 1'b0; ef = 1'b0; ep = 1'b0; ed = 8'h00;
    foreach (recs[i]) begin
      if (c >= recs[i].n + 3 && c <= recs[i].busy_end) eb = 1'b1;
      if (recs[i].pulse == c) begin
        if (recs[i].kind == 1) ev = 1'b1;
        if (recs[i].kind == 2) ef = 1'b1;
        if (recs[i].kind == 3) ep = 1'b1;
      end
      if (recs[i].kind == 1 && recs[i].pulse <= c && recs[i].pulse > reset_cyc && recs[i].pulse > best) begin
        best = recs[i].pulse;
        ed   = recs[i].data;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      nvalid++;
      last_valid_cyc = cyc;
      vhist.push_back(bus.data_out);
    end
    if (bus.frame_err === 1'b1) nferr++;
`ifdef RX_PARITY_EN
    if (bus.parity_err === 1'b1) nperr++;
`endif
    if (bus.busy === 1'b1) last_busy_cyc = cyc;
  end

  always @(negedge clk) begin
    logic eb, ev, ef, ep;
    logic [7:0] ed;
    if (chk_on) begin
      model(cyc, eb, ev, ef, ep, ed);
      check("busy", 32'(bus.busy), 32'(eb));
      check("rx_valid", 32'(bus.rx_valid), 32'(ev));
      check("frame_err", 32'(bus.frame_err), 32'(ef));
      check("data_out", 32'(bus.data_out), 32'(ed));
`ifdef RX_PARITY_EN
      check("parity_err", 32'(bus.parity_err), 32'(ep));
`endif
    end
  end

  task automatic wait_cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_rec(input int kind, input logic [7:0] d);
    rec_t r;
    r.n        = cyc;
    r.busy_end = cyc + PULSE_OFS - 1;
    r.pulse    = (kind != 0) ? cyc + PULSE_OFS : -1;
    r.kind     = kind;
    r.data     = d;
    recs.push_back(r);
  endtask

  // abort_kind: 0 none, 1 reset during bit 4, 2 rx_en low during bit 4
  task automatic drive_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                             input int abort_kind);
    logic [10:0] fr;
    int nb;
    fr = '1;
    fr[0] = 1'b0;
    for (int k = 0; k < 8; k++) fr[k+1] = d[k];
`ifdef RX_PARITY_EN
    fr[9]  = (^d) ^ par_flip;
    fr[10] = stop_b;
    nb     = 11;
`else
    fr[9] = stop_b;
    nb    = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      bus.rx = fr[i];
      for (int j = 0; j < int'(B); j++) begin
        if (i == 5 && j == 5) begin
          if (abort_kind == 1) begin
            reset     = 1'b0;
            reset_cyc = cyc;
            recs[recs.size()-1].busy_end = cyc - 1;
          end else if (abort_kind == 2) begin
            bus.rx_en = 1'b0;
            recs[recs.size()-1].busy_end = cyc;
          end
        end
        @(posedge clk);
        #1;
      end
    end
    bus.rx    = 1'b1;
    reset     = 1'b1;
    bus.rx_en = 1'b1;
  endtask

  initial begin
    int n0, v0, f0;
    bus.rx    = 1'b1;
    bus.rx_en = 1'b1;
    reset     = 1'b1;
    #2 reset  = 1'b0;
    wait_cycles(3);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'h00);
    reset  = 1'b1;
    chk_on = 1'b1;
    wait_cycles(5);

    // 0xA5 good frame, check absolute latency
    n0 = cyc; v0 = nvalid;
    start_rec(1, 8'hA5);
    drive_frame(8'hA5, 1'b1, 1'b0, 0);
    wait_cycles(int'(B));
    check("a5_pulse_count", 32'(nvalid - v0), 32'd1);
    check("a5_latency", 32'(last_valid_cyc - n0), 32'(LAT));
    check("a5_data", 32'(bus.data_out), 32'hA5);

    // short low glitch: false start
    n0 = cyc; v0 = nvalid; f0 = nferr;
    start_rec(0, 8'h00);
    recs[recs.size()-1].busy_end = n0 + 2 + int'(HALF);
    bus.rx = 1'b0;
    wait_cycles(int'(HALF) - 4);
    bus.rx = 1'b1;
    wait_cycles(2 * int'(B));
    check("glitch_busy_last", 32'(last_busy_cyc - n0), 32'd14);
    check("glitch_no_pulse", 32'((nvalid - v0) + (nferr - f0)), 32'd0);

    // 0x3C with low stop bit
    v0 = nvalid; f0 = nferr;
    start_rec(2, 8'h3C);
    drive_frame(8'h3C, 1'b0, 1'b0, 0);
    wait_cycles(int'(B));
    check("ferr_count", 32'(nferr - f0), 32'd1);
    check("ferr_no_valid", 32'(nvalid - v0), 32'd0);
    check("ferr_data_kept", 32'(bus.data_out), 32'hA5);

    // break: line held low for many bit times
    v0 = nvalid; f0 = nferr;
    start_rec(2, 8'h00);
    bus.rx = 1'b0;
    wait_cycles(15 * int'(B));
    bus.rx = 1'b1;
    wait_cycles(2 * int'(B));
    check("break_ferr_once", 32'(nferr - f0), 32'd1);
    check("break_no_valid", 32'(nvalid - v0), 32'd0);
    check("break_idle", 32'(bus.busy), 32'd0);

    // back-to-back 0x00 then 0xFF, no idle gap
    v0 = nvalid;
    start_rec(1, 8'h00);
    drive_frame(8'h00, 1'b1, 1'b0, 0);
    start_rec(1, 8'hFF);
    drive_frame(8'hFF, 1'b1, 1'b0, 0);
    wait_cycles(int'(B));
    check("b2b_count", 32'(nvalid - v0), 32'd2);
    if (nvalid - v0 == 2) begin
      check("b2b_first", 32'(vhist[v0]), 32'h00);
      check("b2b_second", 32'(vhist[v0+1]), 32'hFF);
    end
    check("b2b_data", 32'(bus.data_out), 32'hFF);

    // reset during bit 4 of 0x55, then 0x81
    v0 = nvalid; f0 = nferr;
    start_rec(0, 8'h55);
    drive_frame(8'h55, 1'b1, 1'b0, 1);
    wait_cycles(2 * int'(B));
    check("rst_abort_no_pulse", 32'((nvalid - v0) + (nferr - f0)), 32'd0);
    check("rst_abort_data", 32'(bus.data_out), 32'h00);
    start_rec(1, 8'h81);
    drive_frame(8'h81, 1'b1, 1'b0, 0);
    wait_cycles(int'(B));
    check("after_rst_count", 32'(nvalid - v0), 32'd1);
    check("after_rst_data", 32'(bus.data_out), 32'h81);

    // rx_en dropped mid-frame
    v0 = nvalid; f0 = nferr;
    start_rec(0, 8'h3C);
    drive_frame(8'h3C, 1'b1, 1'b0, 2);
    wait_cycles(2 * int'(B));
    check("en_abort_no_pulse", 32'((nvalid - v0) + (nferr - f0)), 32'd0);
    check("en_abort_data", 32'(bus.data_out), 32'h81);

`ifdef RX_PARITY_EN
    // 0x07: correct parity bit is 1
    v0 = nvalid;
    start_rec(1, 8'h07);
    drive_frame(8'h07, 1'b1, 1'b0, 0);
    wait_cycles(int'(B));
    check("par_ok_count", 32'(nvalid - v0), 32'd1);
    check("par_ok_data", 32'(bus.data_out), 32'h07);
    v0 = nvalid; f0 = nperr;
    start_rec(3, 8'h07);
    drive_frame(8'h07, 1'b1, 1'b1, 0);
    wait_cycles(int'(B));
    check("par_bad_count", 32'(nperr - f0), 32'd1);
    check("par_bad_no_valid", 32'(nvalid - v0), 32'd0);
    check("par_bad_data", 32'(bus.data_out), 32'h07);
`endif

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clk cycles per bit (50 MHz / 19200 baud).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx_en  input  1  receiver enable; low forces IDLE.
REQ-005 SHALL have port rx  input  1  serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-006 SHALL have port data_out  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse, new byte on data_out.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, plus PARITY when RX_PARITY_EN is defined.
REQ-012 SHALL use one bit counter, width ceil(log2(BAUD_DIV)), and one 3-bit data index.
REQ-013 IDLE: if rx_en=1 and rx_s=0 in cycle t0, enter START with counter cleared.
REQ-014 START: sample rx_s at cycle t0+BAUD_DIV/2 (integer division); 0 -> DATA; 1 -> IDLE (false start, no output pulse).
REQ-015 DATA: sample bit i (i=0..7) at t0+BAUD_DIV/2+(i+1)*BAUD_DIV; shift into shift register LSB first; after bit 7 -> STOP (or PARITY).
REQ-016 STOP: sample at t0+BAUD_DIV/2+9*BAUD_DIV (10* with parity); 1 -> load data_out and pulse rx_valid; 0 -> pulse frame_err, data_out unchanged.
REQ-017 rx_valid and frame_err SHALL assert exactly one cycle, the cycle after the stop sample; never both together.
REQ-018 SHALL return to IDLE in the cycle after the stop sample (mid stop bit) so a start edge is detectable immediately after.
REQ-019 rx_en=0 in any state SHALL return to IDLE next cycle, discard the partial frame, and produce no pulses.
REQ-020 data_out SHALL hold its value between valid frames.
REQ-021 busy SHALL be high from the cycle after t0 until the cycle IDLE is re-entered.
REQ-022 rx held low continuously (break) SHALL give frame_err once and SHALL NOT restart until rx_s has been seen high in IDLE.

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, counter 0, index 0, shift register 0x00.
REQ-024 reset SHALL force data_out=0x00, rx_valid=0, frame_err=0, busy=0, and synchronizer flops to 1.
REQ-025 reset asserted mid-frame SHALL abandon the frame with no pulse after release.

Configuration
REQ-026 Macro RX_PARITY_EN defined: frame carries an even-parity bit after bit 7; PARITY state samples it at t0+BAUD_DIV/2+9*BAUD_DIV.
REQ-027 With RX_PARITY_EN: output parity_err (1 bit) pulses with the stop-sample result cycle when parity mismatches; data_out SHALL NOT load and rx_valid SHALL NOT pulse on mismatch.
REQ-028 Without RX_PARITY_EN: no PARITY state, no parity_err port, 10-bit frame.

Verification
REQ-029 Send 0xA5 (8N1, BAUD_DIV=2604) -> one rx_valid pulse, data_out=0xA5, pulse cycle = start edge + 2 sync + 1302 + 9*2604 + 1.
REQ-030 rx low glitch of 500 cycles -> no rx_valid/frame_err, busy falls by cycle 1302+3 after edge.
REQ-031 0x3C with stop bit low -> frame_err pulse once, data_out keeps previous 0xA5.
REQ-032 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_valid pulses, values 0x00, 0xFF.
REQ-033 reset=0 during bit 4 of 0x55, then resend 0x81 -> no pulse for aborted frame, data_out=0x81.
REQ-034 RX_PARITY_EN: 0x07 with parity 1 -> rx_valid; with parity 0 -> parity_err pulse, data_out unchanged.
